clk_div_bank: RTL

- Multi-channel, runtime-programmable clock divider. It is the parametrised successor of the fixed divide-by-18 divider.
- Generates N_CH independent divided square waves plus single-cycle tick enables from one fast clock.
- Divide ratio, enable and ratio-update handshake are per channel.
- Feeds slow-clock and strobe consumers: CPU step clock, display scan, UART baud.

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clk_div_bank_if.sv | 17 +
 rtl/clk_div_chan.sv | 75 +++++++
 rtl/clk_div_bank.sv | 54 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults, channel-select width helper and the per-channel state layout
// for the clk_div_bank divider family.
package clk_div_pkg;

  localparam int DIV_W_DEFAULT   = 8;
  // D=8 reproduces the legacy divide-by-18 divider (toggle every 9 cycles).
  localparam int DEF_DIV_DEFAULT = 8;

  // Width of a channel index; a single-channel bank still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0] cnt;
    logic [DIV_W_DEFAULT-1:0] div;
    logic [DIV_W_DEFAULT-1:0] shadow;
    logic                     pending;
    logic                     clk;
    logic                     tick;
  } chan_state_t;

endpackage

// File: rtl/clk_div_bank_if.sv
// Divide-ratio update handshake into the divider bank.
//
// Handshake: the master holds cfg_valid with a stable cfg_ch/cfg_div until it
// sees cfg_ready; the offer is taken on the clko edge where both are high.
// cfg_ready never depends on cfg_valid.
interface clk_div_bank_if #(
  parameter int DIV_W = 8,
  parameter int CH_W  = 2
);
  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, registered square wave and rise
// tick, plus a shadow divide value applied only at a period boundary.
module clk_div_chan #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 8
) (
  input  logic             clko,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             clk,
  output logic             tick,
  output logic             pending
);

  typedef struct packed {
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic             pending;
    logic             clk;
    logic             tick;
  } st_t;

  st_t q;
  st_t d;

  always_comb begin
    d      = q;
    d.tick = 1'b0;
    // load is only raised while pending is clear, so it never meets an apply.
    if (load) begin
      d.shadow  = load_val;
      d.pending = 1'b1;
    end
    if (!en) begin
      d.cnt = '0;
      d.clk = 1'b0;
      if (q.pending) begin
        d.div     = q.shadow;
        d.pending = 1'b0;
      end
    end else if (q.cnt == q.div) begin
      d.cnt  = '0;
      d.clk  = ~q.clk;
      d.tick = ~q.clk;
      // The falling toggle closes a period: the new ratio starts with a full low phase.
      if (q.clk && q.pending) begin
        d.div     = q.shadow;
        d.pending = 1'b0;
      end
    end else begin
      d.cnt = q.cnt + 1'b1;
    end
  end

  always_ff @(posedge clko) begin
    if (rst) begin
      q.cnt     <= '0;
      q.div     <= DIV_W'(DEF_DIV);
      q.shadow  <= DIV_W'(DEF_DIV);
      q.pending <= 1'b0;
      q.clk     <= 1'b0;
      q.tick    <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign clk     = q.clk;
  assign tick    = q.tick;
  assign pending = q.pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent runtime-programmable clock dividers sharing one
// ratio-update port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DEF_DIV = DEF_DIV_DEFAULT,
  parameter int CH_W    = ch_width(N_CH)
) (
  input  logic              clko,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  clk_div_bank_if.slave     cfg,
  output logic [N_CH-1:0]   clk,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   busy
);

  logic in_range;
  logic pend_sel;

  // Widened compare so a non-power-of-two bank rejects the unused codes.
  assign in_range = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(N_CH));

  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) pend_sel = busy[i];
    end
  end

  assign cfg.cfg_ready = in_range && !pend_sel;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    logic load;
    assign load = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clko     (clko),
      .rst      (rst),
      .en       (en[g]),
      .load     (load),
      .load_val (cfg.cfg_div),
      .clk      (clk[g]),
      .tick     (tick[g]),
      .pending  (busy[g])
    );
  end

endmodule
